// File: rtl/load_store_if.sv
// load_store_if: request/response and data-memory signals of the load/store unit
interface load_store_if;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  opcode;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        resp_valid;
   logic [31:0] load_data;
   logic        misalign;
   logic        illegal;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] mem_read_data;
   modport slave (
      input  req_valid, opcode, addr, store_data, mem_read_data,
      output req_ready, resp_valid, load_data, misalign, illegal,
             mem_address, mem_write_data, MemRead, MemWrite
   );
   modport master (
      output req_valid, opcode, addr, store_data, mem_read_data,
      input  req_ready, resp_valid, load_data, misalign, illegal,
             mem_address, mem_write_data, MemRead, MemWrite
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: MIPS byte-addressed loads/stores over a word memory, sub-word stores by read-modify-write
module load_store_unit #(
   parameter int WAIT_CYCLES = 1
) (
   input logic clk,
   input logic reset,
   load_store_if.slave bus
);
   localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24,
                          LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;
   localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [5:0] op;
   logic [1:0] a2;
   logic [15:0] sd;
   logic legal, mis, is_load, last;
   logic [4:0] sh_amt;
   logic [7:0] rbyte;
   logic [15:0] rhalf;
   logic [31:0] ext, mask, merged;
   always_comb begin
      legal = bus.opcode inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
      mis = ((bus.opcode inside {LH, LHU, SH}) && bus.addr[0]) ||
            ((bus.opcode inside {LW, SW}) && bus.addr[1:0] != 2'b00);
      is_load = op inside {LB, LH, LW, LBU, LHU};
      last = cnt == CW'(WAIT_CYCLES - 1);
      sh_amt = {a2, 3'b000};
      rbyte = 8'(bus.mem_read_data >> sh_amt);
      rhalf = a2[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
      ext = op == LB  ? {{24{rbyte[7]}}, rbyte} :
            op == LBU ? {24'b0, rbyte} :
            op == LH  ? {{16{rhalf[15]}}, rhalf} :
            op == LHU ? {16'b0, rhalf} : bus.mem_read_data;
      mask = op == SB ? 32'h0000_00FF : 32'h0000_FFFF;
      merged = (bus.mem_read_data & ~(mask << sh_amt)) | (({16'b0, sd} & mask) << sh_amt);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         op <= '0;
         a2 <= '0;
         sd <= '0;
         bus.req_ready <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.load_data <= '0;
         bus.misalign <= 1'b0;
         bus.illegal <= 1'b0;
         bus.mem_address <= '0;
         bus.mem_write_data <= '0;
         bus.MemRead <= 1'b0;
         bus.MemWrite <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               op <= bus.opcode;
               a2 <= bus.addr[1:0];
               sd <= bus.store_data[15:0];
               cnt <= '0;
               bus.req_ready <= 1'b0;
               bus.load_data <= '0;
               bus.misalign <= legal && mis;
               bus.illegal <= !legal;
               if (!legal || mis) begin
                  state <= RESP;
                  bus.resp_valid <= 1'b1;
               end else if (bus.opcode == SW) begin
                  state <= WRITE;
                  bus.mem_address <= bus.addr >> 2;
                  bus.mem_write_data <= bus.store_data;
                  bus.MemWrite <= 1'b1;
               end else begin
                  state <= READ;
                  bus.mem_address <= bus.addr >> 2;
                  bus.MemRead <= 1'b1;
               end
            end
            READ: if (last) begin
               bus.MemRead <= 1'b0;
               if (is_load) begin
                  state <= RESP;
                  bus.load_data <= ext;
                  bus.resp_valid <= 1'b1;
               end else begin
                  state <= WRITE;
                  bus.mem_write_data <= merged;
                  bus.MemWrite <= 1'b1;
               end
            end else cnt <= cnt + 1'b1;
            WRITE: begin
               state <= RESP;
               bus.MemWrite <= 1'b0;
               bus.resp_valid <= 1'b1;
            end
            default: begin
               state <= IDLE;
               bus.resp_valid <= 1'b0;
               bus.req_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed requests checked against a byte-array memory model
module tb_load_store_unit;
   localparam int W = 2;
   localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24,
                          LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;
   logic clk = 1'b0;
   logic reset = 1'b1;
   load_store_if bus();
   load_store_unit #(.WAIT_CYCLES(W)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   logic [31:0] mem [16];
   logic [7:0] bm [64];
   logic pl_en = 1'b0;
   logic [3:0] pl_idx = '0;
   logic [31:0] pl_data = '0;
   int rd_cnt = 0, rd_cyc = 0, wr_cyc = 0;
   logic [31:0] rd_addr = '0;
   int errors = 0, checks = 0;

   // memory only returns real data once MemRead has been held W cycles at one address
   assign bus.mem_read_data = (bus.MemRead && (rd_cnt == 0 || bus.mem_address == rd_addr) && rd_cnt + 1 >= W)
                              ? mem[bus.mem_address[3:0]] : 32'hDEAD_BEEF;
   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_data;
      if (bus.MemWrite) mem[bus.mem_address[3:0]] <= bus.mem_write_data;
      if (bus.MemRead) begin
         rd_cnt <= (rd_cnt == 0 || bus.mem_address == rd_addr) ? rd_cnt + 1 : 1;
         rd_addr <= bus.mem_address;
      end else rd_cnt <= 0;
      rd_cyc <= rd_cyc + (bus.MemRead ? 1 : 0);
      wr_cyc <= wr_cyc + (bus.MemWrite ? 1 : 0);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic preload(input int i, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 4'(i); pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
      for (int k = 0; k < 4; k++) bm[4*i+k] = d[8*k +: 8];
   endtask

   function automatic logic [31:0] ref_word(input int i);
      return {bm[4*i+3], bm[4*i+2], bm[4*i+1], bm[4*i]};
   endfunction

   task automatic do_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input bit hold, input string tag);
      int b, n, r0, w0, abad, rbad, both, exp_lat, exp_rd, exp_wr;
      bit ill, mis, load;
      logic [31:0] exp_ld;
      logic [15:0] h;
      b = int'(a[5:0]);
      ill = !(op inside {LB, LH, LW, LBU, LHU, SB, SH, SW});
      mis = !ill && (((op inside {LH, LHU, SH}) && a[0]) || ((op inside {LW, SW}) && a[1:0] != 0));
      load = op inside {LB, LH, LW, LBU, LHU};
      exp_ld = 0;
      h = {bm[b|1], bm[b & ~1]};
      if (!ill && !mis) begin
         case (op)
            LB: exp_ld = {{24{bm[b][7]}}, bm[b]};
            LBU: exp_ld = {24'b0, bm[b]};
            LH: exp_ld = {{16{h[15]}}, h};
            LHU: exp_ld = {16'b0, h};
            LW: exp_ld = ref_word(b / 4);
            SB: bm[b] = sd[7:0];
            SH: begin bm[b] = sd[7:0]; bm[b+1] = sd[15:8]; end
            default: for (int k = 0; k < 4; k++) bm[b+k] = sd[8*k +: 8];
         endcase
      end
      exp_lat = (ill || mis) ? 1 : load ? W + 1 : op == SW ? 2 : W + 2;
      exp_rd = (ill || mis || op == SW) ? 0 : W;
      exp_wr = (!ill && !mis && !load) ? 1 : 0;
      bus.req_valid = 1'b1; bus.opcode = op; bus.addr = a; bus.store_data = sd;
      n = 0;
      while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
      check({tag, "_ready"}, 32'(bus.req_ready), 1);
      r0 = rd_cyc; w0 = wr_cyc; abad = 0; rbad = 0; both = 0;
      @(posedge clk);
      for (n = 1; n <= 20; n++) begin
         @(negedge clk);
         if ((bus.MemRead || bus.MemWrite) && bus.mem_address != (a >> 2)) abad++;
         if (bus.MemRead && bus.MemWrite) both++;
         if (bus.req_ready) rbad++;
         if (bus.resp_valid) break;
         if (n == 1) begin
            if (hold) begin
               bus.opcode = 6'($urandom); bus.addr = $urandom; bus.store_data = $urandom;
            end else bus.req_valid = 1'b0;
         end
      end
      if (!hold) bus.req_valid = 1'b0;
      check({tag, "_resp"}, 32'(bus.resp_valid), 1);
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_load_data"}, bus.load_data, exp_ld);
      check({tag, "_misalign"}, 32'(bus.misalign), 32'(mis));
      check({tag, "_illegal"}, 32'(bus.illegal), 32'(ill));
      check({tag, "_reads"}, rd_cyc - r0, exp_rd);
      check({tag, "_writes"}, wr_cyc - w0, exp_wr);
      check({tag, "_addr_bad"}, abad, 0);
      check({tag, "_busy_ready"}, rbad, 0);
      check({tag, "_both_strobes"}, both, 0);
      check({tag, "_mem"}, mem[a[5:2]], ref_word(int'(a[5:2])));
   endtask

   initial begin
      logic [5:0] ops [9];
      int w0;
      ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'h2A};
      bus.req_valid = 1'b0; bus.opcode = '0; bus.addr = '0; bus.store_data = '0;
      for (int i = 0; i < 16; i++) preload(i, $urandom);
      check("rst_ready", 32'(bus.req_ready), 1);
      check("rst_resp", 32'(bus.resp_valid), 0);
      check("rst_load_data", bus.load_data, 0);
      check("rst_flags", {30'b0, bus.misalign, bus.illegal}, 0);
      check("rst_mem_address", bus.mem_address, 0);
      check("rst_mem_write_data", bus.mem_write_data, 0);
      check("rst_strobes", {30'b0, bus.MemRead, bus.MemWrite}, 0);
      reset = 1'b0;
      preload(2, 32'h8000_00F3);
      do_req(LW, 32'h8, 0, 0, "lw");
      check("lw_value", bus.load_data, 32'h8000_00F3);
      preload(2, 32'h0000_F300);
      do_req(LB, 32'h9, 0, 0, "lb");
      check("lb_value", bus.load_data, 32'hFFFF_FFF3);
      do_req(LBU, 32'h9, 0, 0, "lbu");
      check("lbu_value", bus.load_data, 32'h0000_00F3);
      preload(2, 32'h9ABC_0000);
      do_req(LHU, 32'hA, 0, 0, "lhu");
      check("lhu_value", bus.load_data, 32'h0000_9ABC);
      preload(0, 32'h1122_3344);
      do_req(SB, 32'h2, 32'hAB, 0, "sb");
      check("sb_value", mem[0], 32'h11AB_3344);
      preload(0, 32'h1122_3344);
      do_req(SH, 32'h2, 32'hBEEF, 0, "sh");
      check("sh_value", mem[0], 32'hBEEF_3344);
      do_req(SH, 32'h3, 32'h1234, 0, "sh_mis");
      do_req(6'h2A, 32'h4, 0, 0, "illegal");
      preload(0, 32'h1122_3344);
      bus.req_valid = 1'b1; bus.opcode = SB; bus.addr = 32'h2; bus.store_data = 32'hAB;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("rst_rd_in_read", 32'(bus.MemRead), 1);
      w0 = wr_cyc;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_rd_ready", 32'(bus.req_ready), 1);
      check("rst_rd_resp", 32'(bus.resp_valid), 0);
      check("rst_rd_memread", 32'(bus.MemRead), 0);
      repeat (6) @(negedge clk);
      check("rst_rd_no_write", wr_cyc - w0, 0);
      check("rst_rd_mem", mem[0], 32'h1122_3344);
      do_req(SW, 32'h4, 32'hCAFE_F00D, 0, "sw_after_rst");
      do_req(SW, 32'h10, 32'h0102_0304, 1, "b2b_sw");
      do_req(SB, 32'h15, 32'h0000_0077, 1, "b2b_sb");
      do_req(LW, 32'h14, 0, 0, "b2b_lw");
      for (int i = 0; i < 80; i++)
         do_req(ops[$urandom_range(8)], $urandom, $urandom, (i < 79) && $urandom_range(1) == 1, "rnd");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
